// File: rtl/vedacao_pkg.sv
// Shared types and constants for the bottle sealing conveyor controller.
// Consumed by vedacao_ctrl (macro VEDACAO_WATCHDOG_EN) and contador_duzias.
package vedacao_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    TRANSPORT = 3'd1,
    WAIT_CORK = 3'd2,
    SEAL      = 3'd3,
    RELEASE   = 3'd4
  } vedacao_state_e;

  localparam int DUZIA_MAX  = 12;
  localparam int DUZIAS_SAT = 99;
  localparam int T_SEAL_DEF = 4;
  localparam int T_WDOG_DEF = 200;

  // Dozen counter holds at its ceiling instead of wrapping.
  function automatic logic [6:0] duzias_next(input logic [6:0] d);
    return (d >= 7'(DUZIAS_SAT)) ? 7'(DUZIAS_SAT) : d + 7'd1;
  endfunction

endpackage

// File: rtl/contador_duzias.sv
// Bottle / dozen counter: one inc strobe per sealed bottle, saturating dozens,
// one-cycle pulse whenever a dozen closes.
module contador_duzias
  import vedacao_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  output logic [3:0] garrafas,
  output logic [6:0] duzias,
  output logic       duzia_completa
);

  localparam logic [3:0] G_LAST = 4'(DUZIA_MAX - 1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      garrafas       <= 4'd0;
      duzias         <= 7'd0;
      duzia_completa <= 1'b0;
    end else begin
      duzia_completa <= 1'b0;
      if (inc) begin
        if (garrafas == G_LAST) begin
          garrafas       <= 4'd0;
          duzias         <= duzias_next(duzias);
          duzia_completa <= 1'b1;
        end else begin
          garrafas <= garrafas + 4'd1;
        end
      end
    end
  end

endmodule

// File: rtl/vedacao_ctrl.sv
// Conveyor / corking sequencer with registered outputs and dozen counting.
// Optional transport watchdog enabled by defining VEDACAO_WATCHDOG_EN.
//
// state     | meaning
// IDLE      | motor off, waiting for start without parada
// TRANSPORT | motor on, waiting for a bottle under the head
// WAIT_CORK | bottle present, cork counter empty, motor off
// SEAL      | press down for T_SEAL cycles, cork consumed on entry
// RELEASE   | motor on until the sealed bottle leaves the sensor
module vedacao_ctrl
  import vedacao_pkg::*;
#(
  parameter int T_SEAL = T_SEAL_DEF,
  parameter int T_WDOG = T_WDOG_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       parada,
  input  logic       sensor_garrafa,
  input  logic       rolha_disponivel,
  output logic       motor_esteira,
  output logic       atuador_vedacao,
  output logic       dec_rolha,
  output logic       falta_rolha,
  output logic [3:0] garrafas,
  output logic [6:0] duzias,
  output logic       duzia_completa,
  output logic       alarme_wdog
);

  localparam logic [2:0] ST_IDLE      = IDLE;
  localparam logic [2:0] ST_TRANSPORT = TRANSPORT;
  localparam logic [2:0] ST_WAIT_CORK = WAIT_CORK;
  localparam logic [2:0] ST_SEAL      = SEAL;
  localparam logic [2:0] ST_RELEASE   = RELEASE;

  localparam logic [3:0] SEAL_LOAD = 4'(T_SEAL - 1);

  logic [2:0] state;
  logic [2:0] state_nxt;
  logic [3:0] seal_tmr;
  logic       stop_pend;
  logic       seal_done;
  logic       wdog_trip;

  assign seal_done = (state == ST_SEAL) && (seal_tmr == 4'd0);

`ifdef VEDACAO_WATCHDOG_EN
  localparam int WW = $clog2(T_WDOG + 1);

  logic [WW-1:0] wdog_cnt;
  logic          alarme_q;

  assign wdog_trip   = (state == ST_TRANSPORT) && (wdog_cnt == WW'(T_WDOG - 1));
  assign alarme_wdog = alarme_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wdog_cnt <= '0;
      alarme_q <= 1'b0;
    end else begin
      if ((state == ST_TRANSPORT) && (state_nxt == ST_TRANSPORT))
        wdog_cnt <= wdog_cnt + 1'b1;
      else
        wdog_cnt <= '0;
      if (wdog_trip)
        alarme_q <= 1'b1;
    end
  end
`else
  assign wdog_trip   = 1'b0;
  assign alarme_wdog = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start && !parada)
          state_nxt = ST_TRANSPORT;
      end
      ST_TRANSPORT: begin
        if (parada || wdog_trip)
          state_nxt = ST_IDLE;
        else if (sensor_garrafa)
          state_nxt = rolha_disponivel ? ST_SEAL : ST_WAIT_CORK;
      end
      ST_WAIT_CORK: begin
        if (parada)
          state_nxt = ST_IDLE;
        else if (rolha_disponivel)
          state_nxt = ST_SEAL;
      end
      ST_SEAL: begin
        // A stop seen at any point of the seal is honoured only once the press lifts.
        if (seal_done)
          state_nxt = (parada || stop_pend) ? ST_IDLE : ST_RELEASE;
      end
      ST_RELEASE: begin
        if (parada)
          state_nxt = ST_IDLE;
        else if (!sensor_garrafa)
          state_nxt = ST_TRANSPORT;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      seal_tmr  <= 4'd0;
      stop_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      if ((state != ST_SEAL) && (state_nxt == ST_SEAL))
        seal_tmr <= SEAL_LOAD;
      else if ((state == ST_SEAL) && (seal_tmr != 4'd0))
        seal_tmr <= seal_tmr - 4'd1;
      if (state == ST_SEAL)
        stop_pend <= stop_pend | parada;
      else
        stop_pend <= 1'b0;
    end
  end

  // Outputs decoded from the next state so they line up with the state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      motor_esteira   <= 1'b0;
      atuador_vedacao <= 1'b0;
      dec_rolha       <= 1'b0;
      falta_rolha     <= 1'b0;
    end else begin
      motor_esteira   <= (state_nxt == ST_TRANSPORT) || (state_nxt == ST_RELEASE);
      atuador_vedacao <= (state_nxt == ST_SEAL);
      dec_rolha       <= (state_nxt == ST_SEAL) && (state != ST_SEAL);
      falta_rolha     <= (state_nxt == ST_WAIT_CORK);
    end
  end

  contador_duzias u_contador (
    .clk            (clk),
    .reset          (reset),
    .inc            (seal_done),
    .garrafas       (garrafas),
    .duzias         (duzias),
    .duzia_completa (duzia_completa)
  );

endmodule

// File: tb/tb_vedacao_ctrl.sv
// Directed bench for vedacao_ctrl: bottle counts are predicted into a queue
// when a bottle is presented and compared when its seal completes.
module tb_vedacao_ctrl;

  localparam int TS = 4;
  localparam int TW = 200;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       parada;
  logic       sensor_garrafa;
  logic       rolha_disponivel;
  logic       motor_esteira;
  logic       atuador_vedacao;
  logic       dec_rolha;
  logic       falta_rolha;
  logic [3:0] garrafas;
  logic [6:0] duzias;
  logic       duzia_completa;
  logic       alarme_wdog;

  typedef struct {
    int g;
    int d;
    int p;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   exp_g    = 0;
  int   exp_d    = 0;
  int   wd_n     = 0;
  bit   wd_hit   = 1'b0;

  vedacao_ctrl #(.T_SEAL(TS), .T_WDOG(TW)) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .parada           (parada),
    .sensor_garrafa   (sensor_garrafa),
    .rolha_disponivel (rolha_disponivel),
    .motor_esteira    (motor_esteira),
    .atuador_vedacao  (atuador_vedacao),
    .dec_rolha        (dec_rolha),
    .falta_rolha      (falta_rolha),
    .garrafas         (garrafas),
    .duzias           (duzias),
    .duzia_completa   (duzia_completa),
    .alarme_wdog      (alarme_wdog)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_expected();
    exp_t e;
    if (exp_g == 11) begin
      exp_g = 0;
      exp_d = (exp_d >= 99) ? 99 : exp_d + 1;
      e.p   = 1;
    end else begin
      exp_g = exp_g + 1;
      e.p   = 0;
    end
    e.g = exp_g;
    e.d = exp_d;
    sb.push_back(e);
  endtask

  // Present one bottle while in TRANSPORT; optional cork delay and stop pulse.
  task automatic seal_bottle(input int cork_delay, input int parada_at);
    exp_t e;
    int   n_dec;
    int   n_press;
    bit   done;
    bit   prev;
    sensor_garrafa   = 1'b1;
    rolha_disponivel = (cork_delay == 0);
    push_expected();
    n_dec = 0; n_press = 0; done = 1'b0; prev = 1'b0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (cork_delay > 0 && c == 0) begin
        chk("wait_falta_rolha", falta_rolha, 1);
        chk("wait_motor_off", motor_esteira, 0);
      end
      if (cork_delay > 0 && c + 1 == cork_delay) rolha_disponivel = 1'b1;
      parada = (c == parada_at);
      n_dec   += int'(dec_rolha);
      n_press += int'(atuador_vedacao);
      if (prev && !atuador_vedacao) done = 1'b1;
      prev = atuador_vedacao;
    end
    chk("seal_finished", done, 1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("garrafas", garrafas, e.g);
      chk("duzias", duzias, e.d);
      chk("duzia_completa", duzia_completa, e.p);
    end
    chk("dec_rolha_pulses", n_dec, 1);
    chk("press_cycles", n_press, TS);
    chk("motor_after_seal", motor_esteira, (parada_at >= 0) ? 0 : 1);
    sensor_garrafa = 1'b0;
    parada         = 1'b0;
    @(negedge clk);
    chk("resume_transport", motor_esteira, 1);
    chk("duzia_pulse_width", duzia_completa, 0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; parada = 1'b0;
    sensor_garrafa = 1'b0; rolha_disponivel = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_motor", motor_esteira, 0);
    chk("rst_press", atuador_vedacao, 0);
    chk("rst_dec", dec_rolha, 0);
    chk("rst_falta", falta_rolha, 0);
    chk("rst_garrafas", garrafas, 0);
    chk("rst_duzias", duzias, 0);
    chk("rst_pulse", duzia_completa, 0);
    chk("rst_alarm", alarme_wdog, 0);

    reset = 1'b0;
    @(negedge clk);
    chk("idle_no_start", motor_esteira, 0);
    start = 1'b1;
    @(negedge clk);
    chk("start_transport", motor_esteira, 1);

    // V1 plain bottle, V2 cork arrives ten cycles late
    seal_bottle(0, -1);
    seal_bottle(10, -1);

    // start dropped outside IDLE has no effect
    start = 1'b0;
    @(negedge clk);
    chk("start_low_ignored", motor_esteira, 1);
    start = 1'b1;

    // V3 finish the first dozen, then run up to saturation
    repeat (10) seal_bottle(0, -1);
    chk("first_dozen", duzias, 1);
    for (int i = 0; i < 1300 && !(exp_d == 99 && exp_g == 0); i++)
      seal_bottle(0, -1);
    chk("reached_99", duzias, 99);
    repeat (12) seal_bottle(0, -1);
    chk("sat_duzias", duzias, 99);
    chk("sat_garrafas", garrafas, 0);

    // V4 stop during second seal cycle, then stop in TRANSPORT
    seal_bottle(0, 1);
    parada = 1'b1;
    @(negedge clk);
    chk("stop_transport", motor_esteira, 0);
    parada = 1'b0;
    @(negedge clk);
    chk("restart_after_stop", motor_esteira, 1);

    // V5 reset in the middle of a seal
    sensor_garrafa = 1'b1;
    @(negedge clk);
    chk("v5_press_on", atuador_vedacao, 1);
    @(negedge clk);
    chk("v5_count_held", garrafas, exp_g);
    #1 reset = 1'b1;
    #1;
    chk("v5_motor", motor_esteira, 0);
    chk("v5_press", atuador_vedacao, 0);
    chk("v5_dec", dec_rolha, 0);
    chk("v5_garrafas", garrafas, 0);
    chk("v5_duzias", duzias, 0);
    exp_g = 0; exp_d = 0;
    sensor_garrafa = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("v5_restart", motor_esteira, 1);
    seal_bottle(0, -1);

`ifdef VEDACAO_WATCHDOG_EN
    // V6 no bottle arrives while transporting
    for (int c = 0; c < 400 && !wd_hit; c++) begin
      @(negedge clk);
      wd_n++;
      if (alarme_wdog === 1'b1) wd_hit = 1'b1;
    end
    chk("wdog_fired", wd_hit, 1);
    chk("wdog_timing", (wd_n >= TW - 5 && wd_n <= TW + 5), 1);
    chk("wdog_idle", motor_esteira, 0);
    repeat (5) @(negedge clk);
    chk("wdog_sticky", alarme_wdog, 1);
    reset = 1'b1;
    @(negedge clk);
    chk("wdog_cleared", alarme_wdog, 0);
    reset = 1'b0;
`else
    repeat (TW + 50) @(negedge clk);
    chk("no_wdog_motor", motor_esteira, 1);
    chk("no_wdog_alarm", alarme_wdog, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vedacao_ctrl.md
VEDACAO_CTRL -- requirements
Module: vedacao_ctrl

Interface
REQ-001 Parameter: T_SEAL, default 4, sealing actuator hold time in clock cycles (range 1..15).
REQ-002 Parameter: T_WDOG, default 200, cycles allowed in TRANSPORT without a bottle arriving (watchdog build only).
REQ-003 Signal: clk  in  1  system clock; all state changes on rising edge.
REQ-004 Signal: reset  in  1  reset, asynchronous, active-high.
REQ-005 Signal: start  in  1  level; begin or continue the conveyor process.
REQ-006 Signal: parada  in  1  level; stop request.
REQ-007 Signal: sensor_garrafa  in  1  bottle present under the sealing head.
REQ-008 Signal: rolha_disponivel  in  1  cork counter holds at least one cork.
REQ-009 Signal: motor_esteira  out  1  conveyor motor on.
REQ-010 Signal: atuador_vedacao  out  1  sealing press down.
REQ-011 Signal: dec_rolha  out  1  one-cycle pulse that consumes one cork from the cork counter.
REQ-012 Signal: falta_rolha  out  1  bottle waiting, no cork available.
REQ-013 Signal: garrafas  out  4  bottles sealed in the current dozen, 0..11.
REQ-014 Signal: duzias  out  7  completed dozens, 0..99.
REQ-015 Signal: duzia_completa  out  1  one-cycle pulse when a dozen closes.
REQ-016 Signal: alarme_wdog  out  1  sticky watchdog alarm.

Function
REQ-017 The FSM SHALL have states IDLE, TRANSPORT, WAIT_CORK, SEAL, and RELEASE; all outputs SHALL be registered.
REQ-018 IDLE: motor 0, press 0; start=1 and parada=0 -> TRANSPORT.
REQ-019 TRANSPORT: motor 1; sensor_garrafa=1 with rolha_disponivel=1 -> SEAL; sensor_garrafa=1 with rolha_disponivel=0 -> WAIT_CORK.
REQ-020 WAIT_CORK: motor 0, falta_rolha 1; rolha_disponivel=1 -> SEAL.
REQ-021 dec_rolha SHALL be 1 only during the first cycle of each SEAL visit, giving exactly one pulse per bottle.
REQ-022 SEAL: motor 0, press 1 for exactly T_SEAL cycles; on exit, bottle count +1 and -> RELEASE.
REQ-023 RELEASE: motor 1, press 0; stay until sensor_garrafa=0, then -> TRANSPORT, so the same bottle is never sealed twice.
REQ-024 parada=1 in TRANSPORT, WAIT_CORK, or RELEASE -> IDLE next cycle; parada in SEAL is deferred until SEAL completes, then -> IDLE.
REQ-025 Counting: garrafas 11 -> 0 with duzias +1 and duzia_completa pulsed in the same cycle.
REQ-026 duzias SHALL saturate at 99; the pulse still fires at saturation.
REQ-027 start=0 while not in IDLE has no effect; only parada stops the block.

Reset
REQ-028 reset=1 SHALL force, asynchronously: state IDLE, all outputs 0, garrafas 0, duzias 0, seal timer 0, watchdog counter 0, alarme_wdog 0.
REQ-029 reset mid-SEAL SHALL abort the seal without incrementing the count; the consumed cork is not restored.

Configuration
REQ-030 Macro VEDACAO_WATCHDOG_EN defined: the watchdog counter runs in TRANSPORT, clears on leaving TRANSPORT, and on reaching T_WDOG sets alarme_wdog (sticky until reset) and forces IDLE.
REQ-031 Without VEDACAO_WATCHDOG_EN: no watchdog logic; alarme_wdog tied 0.

Structure
REQ-032 Shared package vedacao_pkg SHALL hold the state enum, DUZIA_MAX=12, DUZIAS_SAT=99, and the default T_SEAL and T_WDOG.
REQ-033 Sub-module contador_duzias SHALL implement the garrafas/duzias/duzia_completa counting, driven by a single increment strobe.

Verification
REQ-034 V1: reset, start=1, bottle arrives with cork available -> dec_rolha exactly one cycle, press high 4 cycles, garrafas=1.
REQ-035 V2: bottle arrives with rolha_disponivel=0 -> WAIT_CORK, falta_rolha=1, motor 0; cork appears 10 cycles later -> single dec_rolha and normal seal.
REQ-036 V3: 12 bottles in sequence -> garrafas returns to 0, duzias=1, one duzia_completa pulse; preload to 99 dozens then 12 more bottles -> duzias stays 99.
REQ-037 V4: parada asserted in the second SEAL cycle -> seal completes (4 cycles), count increments, then IDLE; parada in TRANSPORT -> IDLE next cycle.
REQ-038 V5: reset asserted mid-SEAL -> all outputs 0 immediately, garrafas unchanged from before the seal (0 after reset).
REQ-039 V6 (VEDACAO_WATCHDOG_EN): no bottle for 200 cycles in TRANSPORT -> alarme_wdog=1, IDLE; it stays 1 through start until reset.
